// File: rtl/alu_issue_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_stage_pkg
// Shared constants for the ALU issue stage and the ALU itself:
//   - ALUControl operation codes (AND/OR/ADD/SUB)
//   - ALUOp encodings produced by the main decoder
//   - funct3 values that the R-type decode distinguishes
//   - the control bundle stored per buffered operation
//   - the occupancy states of the 2-entry skid buffer
// -----------------------------------------------------------------------------
package alu_issue_stage_pkg;

   // ALUControl codes understood by the ALU
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   // ALUOp encodings from the main decoder
   localparam logic [1:0] ALUOP_LDST   = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_RSVD   = 2'b11;

   // funct3 values recognised for R-type operations
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   // Decoded control carried alongside the operands of each entry
   typedef struct packed {
      logic [3:0] code;
      logic       illegal;
   } ctrl_t;

   // Number of entries held in the head/skid pair
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

endpackage : alu_issue_stage_pkg

// File: rtl/alu_issue_stage_if.sv
// -----------------------------------------------------------------------------
// alu_issue_stage_if
// Bundles both handshakes of the issue stage:
//   input side : InValid/InReady with ALUOp, Funct3, Funct7b5, A, B
//   output side: OutValid/OutReady with X, Y, ALUControl, Illegal
//   status     : IssueCount (saturating count of output handshakes)
// Modports:
//   slave  - the issue stage itself (accepts operations, presents results)
//   master - its surroundings (decode stage driving inputs, ALU consuming)
// -----------------------------------------------------------------------------
interface alu_issue_stage_if #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 16
);
   logic             InValid;
   logic             InReady;
   logic [1:0]       ALUOp;
   logic [2:0]       Funct3;
   logic             Funct7b5;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;

   logic             OutValid;
   logic             OutReady;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic [3:0]       ALUControl;
   logic             Illegal;
   logic [CNT_W-1:0] IssueCount;

   modport slave (
      input  InValid, ALUOp, Funct3, Funct7b5, A, B, OutReady,
      output InReady, OutValid, X, Y, ALUControl, Illegal, IssueCount
   );

   modport master (
      output InValid, ALUOp, Funct3, Funct7b5, A, B, OutReady,
      input  InReady, OutValid, X, Y, ALUControl, Illegal, IssueCount
   );

endinterface : alu_issue_stage_if

// File: rtl/alu_issue_stage_ctrl_decode.sv
// -----------------------------------------------------------------------------
// alu_ctrl_decode
// Purely combinational translation of ALUOp/funct3/funct7[5] into the 4-bit
// ALU operation code. Unsupported encodings fall back to ADD and raise the
// illegal flag so the downstream ALU still sees a harmless operation.
// Ports:
//   alu_op   in  2  ALUOp from the main decoder
//   funct3   in  3  instruction funct3
//   funct7b5 in  1  instruction bit 30
//   ctl      out    {code, illegal}
// -----------------------------------------------------------------------------
module alu_ctrl_decode
   import alu_issue_stage_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output ctrl_t      ctl
);

   always_comb begin
      ctl.code    = ALU_ADD;
      ctl.illegal = 1'b0;
      case (alu_op)
         ALUOP_LDST:   ctl.code = ALU_ADD;
         ALUOP_BRANCH: ctl.code = ALU_SUB;
         ALUOP_RTYPE: begin
            case (funct3)
               F3_ADD_SUB: ctl.code = funct7b5 ? ALU_SUB : ALU_ADD;
               F3_AND:     ctl.code = ALU_AND;
               F3_OR:      ctl.code = ALU_OR;
               default:    ctl.illegal = 1'b1;
            endcase
         end
         default: ctl.illegal = 1'b1;
      endcase
   end

endmodule : alu_ctrl_decode

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Registered issue stage in front of the 64-bit ALU. Operations are decoded
// on acceptance and held in a 2-entry buffer (head + skid) so the upstream
// ready never depends combinationally on the ALU's ready.
// Ports:
//   clk    in  clock, all state on the rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of alu_issue_stage_if:
//          InValid/InReady + ALUOp/Funct3/Funct7b5/A/B  (input side)
//          OutValid/OutReady + X/Y/ALUControl/Illegal   (output side)
//          IssueCount                                    (saturating pop count)
// -----------------------------------------------------------------------------
module alu_issue_stage
   import alu_issue_stage_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_issue_stage_if.slave   bus
);

   ctrl_t            dec_ctl;

   occ_e             occ_q,      occ_d;
   logic [WIDTH-1:0] head_x_q,   head_x_d;
   logic [WIDTH-1:0] head_y_q,   head_y_d;
   ctrl_t            head_ctl_q, head_ctl_d;
   logic [WIDTH-1:0] skid_x_q,   skid_x_d;
   logic [WIDTH-1:0] skid_y_q,   skid_y_d;
   ctrl_t            skid_ctl_q, skid_ctl_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;

   logic             in_ready;
   logic             out_valid;
   logic             push;
   logic             pop;

   alu_ctrl_decode u_decode (
      .alu_op   (bus.ALUOp),
      .funct3   (bus.Funct3),
      .funct7b5 (bus.Funct7b5),
      .ctl      (dec_ctl)
   );

   // Both handshake flags come from the occupancy register only, which keeps
   // OutReady->InReady and InValid->OutValid free of combinational paths.
   assign in_ready  = (occ_q != OCC_TWO);
   assign out_valid = (occ_q != OCC_EMPTY);
   assign push      = bus.InValid && in_ready;
   assign pop       = out_valid && bus.OutReady;

   // Occupancy FSM and entry movement
   always_comb begin
      occ_d      = occ_q;
      head_x_d   = head_x_q;
      head_y_d   = head_y_q;
      head_ctl_d = head_ctl_q;
      skid_x_d   = skid_x_q;
      skid_y_d   = skid_y_q;
      skid_ctl_d = skid_ctl_q;

      case (occ_q)
         OCC_EMPTY: begin
            if (push) begin
               head_x_d   = bus.A;
               head_y_d   = bus.B;
               head_ctl_d = dec_ctl;
               occ_d      = OCC_ONE;
            end
         end
         OCC_ONE: begin
            if (push && pop) begin
               // Head is consumed this edge, so the new entry replaces it.
               head_x_d   = bus.A;
               head_y_d   = bus.B;
               head_ctl_d = dec_ctl;
            end else if (push) begin
               skid_x_d   = bus.A;
               skid_y_d   = bus.B;
               skid_ctl_d = dec_ctl;
               occ_d      = OCC_TWO;
            end else if (pop) begin
               occ_d      = OCC_EMPTY;
            end
         end
         OCC_TWO: begin
            if (pop) begin
               head_x_d   = skid_x_q;
               head_y_d   = skid_y_q;
               head_ctl_d = skid_ctl_q;
               occ_d      = OCC_ONE;
            end
         end
         default: occ_d = OCC_EMPTY;
      endcase
   end

   // Saturating issue counter
   always_comb begin
      cnt_d = cnt_q;
      if (pop && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q      <= OCC_EMPTY;
         head_x_q   <= '0;
         head_y_q   <= '0;
         head_ctl_q <= '0;
         skid_x_q   <= '0;
         skid_y_q   <= '0;
         skid_ctl_q <= '0;
         cnt_q      <= '0;
      end else begin
         occ_q      <= occ_d;
         head_x_q   <= head_x_d;
         head_y_q   <= head_y_d;
         head_ctl_q <= head_ctl_d;
         skid_x_q   <= skid_x_d;
         skid_y_q   <= skid_y_d;
         skid_ctl_q <= skid_ctl_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.InReady    = in_ready;
   assign bus.OutValid   = out_valid;
   assign bus.X          = head_x_q;
   assign bus.Y          = head_y_q;
   assign bus.ALUControl = head_ctl_q.code;
   assign bus.Illegal    = head_ctl_q.illegal;
   assign bus.IssueCount = cnt_q;

endmodule : alu_issue_stage

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
// Directed bench for alu_issue_stage (WIDTH=64, CNT_W=4). Inputs are driven
// and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

   localparam int WIDTH = 64;
   localparam int CNT_W = 4;

   logic clk;
   logic rst_n;

   int n_checks = 0;
   int n_errors = 0;

   alu_issue_stage_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   alu_issue_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                        input logic f7, input logic [63:0] a, input logic [63:0] b);
      bus.InValid  = v;
      bus.ALUOp    = op;
      bus.Funct3   = f3;
      bus.Funct7b5 = f7;
      bus.A        = a;
      bus.B        = b;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b0, 2'b00, 3'b000, 1'b0, 64'd0, 64'd0);
      step();
      rst_n = 1'b1;
   endtask

   // Decode sweep table: {ALUOp, Funct3, Funct7b5} -> {ALUControl, Illegal}
   logic [1:0] v_op  [9] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
   logic [2:0] v_f3  [9] = '{3'b111, 3'b110, 3'b000, 3'b000, 3'b101, 3'b011, 3'b001, 3'b000, 3'b101};
   logic       v_f7  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [3:0] v_ctl [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0010, 4'b0110, 4'b0010, 4'b0010, 4'b0010};
   logic       v_ill [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   initial begin
      rst_n        = 1'b0;
      bus.OutReady = 1'b0;
      drive(1'b0, 2'b00, 3'b000, 1'b0, 64'd0, 64'd0);

      // Reset state
      step();
      check("rst_outvalid", 64'(bus.OutValid), 64'd0);
      check("rst_inready", 64'(bus.InReady), 64'd1);
      check("rst_x", bus.X, 64'd0);
      check("rst_ctl", 64'(bus.ALUControl), 64'd0);
      check("rst_cnt", 64'(bus.IssueCount), 64'd0);
      rst_n = 1'b1;

      // Decode sweep, one operation per cycle
      bus.OutReady = 1'b1;
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, v_op[i], v_f3[i], v_f7[i], 64'(100 + i), 64'(200 + i));
         step();
         check($sformatf("dec%0d_valid", i), 64'(bus.OutValid), 64'd1);
         check($sformatf("dec%0d_ctl", i), 64'(bus.ALUControl), 64'(v_ctl[i]));
         check($sformatf("dec%0d_ill", i), 64'(bus.Illegal), 64'(v_ill[i]));
         check($sformatf("dec%0d_x", i), bus.X, 64'(100 + i));
         check($sformatf("dec%0d_y", i), bus.Y, 64'(200 + i));
      end
      drive(1'b0, 2'b00, 3'b000, 1'b0, 64'd0, 64'd0);
      step();
      check("dec_drain", 64'(bus.OutValid), 64'd0);
      check("dec_cnt", 64'(bus.IssueCount), 64'd9);

      // Streaming
      do_reset();
      bus.OutReady = 1'b1;
      drive(1'b1, 2'b00, 3'b000, 1'b0, 64'd10, 64'd23);
      step();
      check("str0_valid", 64'(bus.OutValid), 64'd1);
      check("str0_x", bus.X, 64'd10);
      check("str0_y", bus.Y, 64'd23);
      drive(1'b1, 2'b00, 3'b000, 1'b0, 64'd15, 64'd18);
      step();
      check("str1_x", bus.X, 64'd15);
      check("str1_y", bus.Y, 64'd18);
      drive(1'b1, 2'b00, 3'b000, 1'b0, 64'd5, 64'd5);
      step();
      check("str2_x", bus.X, 64'd5);
      check("str2_y", bus.Y, 64'd5);
      drive(1'b0, 2'b00, 3'b000, 1'b0, 64'd0, 64'd0);
      step();
      check("str_empty", 64'(bus.OutValid), 64'd0);
      check("str_cnt", 64'(bus.IssueCount), 64'd3);

      // Back-pressure
      do_reset();
      bus.OutReady = 1'b0;
      drive(1'b1, 2'b10, 3'b000, 1'b1, 64'd7, 64'd4);
      step();
      check("bp0_inready", 64'(bus.InReady), 64'd1);
      check("bp0_x", bus.X, 64'd7);
      check("bp0_y", bus.Y, 64'd4);
      check("bp0_ctl", 64'(bus.ALUControl), 64'd6);
      drive(1'b1, 2'b00, 3'b000, 1'b0, 64'd7, 64'd8);
      step();
      check("bp1_inready", 64'(bus.InReady), 64'd0);
      check("bp1_y", bus.Y, 64'd4);
      drive(1'b1, 2'b00, 3'b000, 1'b0, 64'd9, 64'd9);
      step();
      check("bp2_inready", 64'(bus.InReady), 64'd0);
      check("bp2_x", bus.X, 64'd7);
      check("bp2_y", bus.Y, 64'd4);
      check("bp2_ctl", 64'(bus.ALUControl), 64'd6);
      drive(1'b0, 2'b00, 3'b000, 1'b0, 64'd0, 64'd0);
      bus.OutReady = 1'b1;
      step();
      check("bp3_x", bus.X, 64'd7);
      check("bp3_y", bus.Y, 64'd8);
      check("bp3_ctl", 64'(bus.ALUControl), 64'd2);
      check("bp3_inready", 64'(bus.InReady), 64'd1);
      check("bp3_valid", 64'(bus.OutValid), 64'd1);
      step();
      check("bp4_valid", 64'(bus.OutValid), 64'd0);
      check("bp4_cnt", 64'(bus.IssueCount), 64'd2);

      // Occupancy 1 with simultaneous push and pop
      do_reset();
      bus.OutReady = 1'b1;
      drive(1'b1, 2'b00, 3'b000, 1'b0, 64'd1, 64'd31);
      step();
      for (int k = 2; k <= 5; k++) begin
         check($sformatf("pp%0d_x", k), bus.X, 64'(k - 1));
         check($sformatf("pp%0d_inready", k), 64'(bus.InReady), 64'd1);
         drive(1'b1, 2'b00, 3'b000, 1'b0, 64'(k), 64'(30 + k));
         step();
      end
      check("pp_last_x", bus.X, 64'd5);
      check("pp_last_y", bus.Y, 64'd35);
      drive(1'b0, 2'b00, 3'b000, 1'b0, 64'd0, 64'd0);
      step();
      check("pp_empty", 64'(bus.OutValid), 64'd0);
      check("pp_cnt", 64'(bus.IssueCount), 64'd5);

      // Asynchronous reset at occupancy 2
      bus.OutReady = 1'b0;
      drive(1'b1, 2'b10, 3'b111, 1'b0, 64'd41, 64'd42);
      step();
      drive(1'b1, 2'b10, 3'b110, 1'b0, 64'd43, 64'd44);
      step();
      check("ar_full", 64'(bus.InReady), 64'd0);
      drive(1'b0, 2'b00, 3'b000, 1'b0, 64'd0, 64'd0);
      #2 rst_n = 1'b0;
      #1;
      check("ar_valid", 64'(bus.OutValid), 64'd0);
      check("ar_inready", 64'(bus.InReady), 64'd1);
      check("ar_x", bus.X, 64'd0);
      check("ar_y", bus.Y, 64'd0);
      check("ar_ctl", 64'(bus.ALUControl), 64'd0);
      check("ar_ill", 64'(bus.Illegal), 64'd0);
      check("ar_cnt", 64'(bus.IssueCount), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.OutReady = 1'b1;
      drive(1'b1, 2'b01, 3'b000, 1'b0, 64'd100, 64'd200);
      step();
      check("ar_post_valid", 64'(bus.OutValid), 64'd1);
      check("ar_post_x", bus.X, 64'd100);
      check("ar_post_ctl", 64'(bus.ALUControl), 64'd6);
      drive(1'b0, 2'b00, 3'b000, 1'b0, 64'd0, 64'd0);
      step();
      check("ar_post_empty", 64'(bus.OutValid), 64'd0);
      check("ar_post_cnt", 64'(bus.IssueCount), 64'd1);

      // Counter saturation: 20 pops with a 4-bit counter
      do_reset();
      bus.OutReady = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 2'b00, 3'b000, 1'b0, 64'(i), 64'(i));
         step();
         if (i == 15) check("sat_mid_cnt", 64'(bus.IssueCount), 64'd15);
      end
      drive(1'b0, 2'b00, 3'b000, 1'b0, 64'd0, 64'd0);
      step();
      check("sat_cnt", 64'(bus.IssueCount), 64'd15);
      check("sat_empty", 64'(bus.OutValid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_alu_issue_stage
